// File: rtl/hilbert_transform_fir.sv
// Streaming Hilbert transformer: run-time loaded FIR gives the imaginary part,
// the input delayed by the group delay (LENGTH-1)/2 gives the real part.
module hilbert_transform_fir #(
    parameter int LENGTH      = 27,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int COEFF_FRAC  = 17
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   enable,
    input  logic [COEFF_WIDTH-1:0] coeffIn,
    input  logic                   coeffValid,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    input  logic                   dataInValid,
    input  logic                   stopDataIn,
    output logic [DATA_WIDTH-1:0]  dataOutRe,
    output logic [DATA_WIDTH-1:0]  dataOutIm,
    output logic                   dataOutValid,
    output logic                   done
);

    localparam int D      = (LENGTH - 1) / 2;
    localparam int CNT_W  = $clog2(LENGTH);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(LENGTH);

    localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(LENGTH - 2);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COEFF = 3'd1,
        MAIN_OP    = 3'd2,
        FLUSH      = 3'd3,
        STOP       = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [COEFF_WIDTH-1:0] coeff_q [LENGTH];
    logic signed [COEFF_WIDTH-1:0] coeff_d [LENGTH];
    logic signed [DATA_WIDTH-1:0]  x_q [LENGTH];
    logic signed [DATA_WIDTH-1:0]  x_d [LENGTH];
    logic [DATA_WIDTH-1:0]         re_q, re_d;
    logic [DATA_WIDTH-1:0]         im_q, im_d;
    logic                          valid_q, valid_d;
    logic                          done_q, done_d;

    logic                          shift;
    logic signed [DATA_WIDTH-1:0]  shift_in;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc;

    // Floor shift (arithmetic >>> rounds toward -inf) then clamp to the output range.
    function automatic logic [DATA_WIDTH-1:0] shift_sat(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] sh;
        sh = sum >>> COEFF_FRAC;
        if (sh > SAT_MAX) begin
            return DATA_WIDTH'(SAT_MAX);
        end else if (sh < SAT_MIN) begin
            return DATA_WIDTH'(SAT_MIN);
        end
        return DATA_WIDTH'(sh);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        coeff_d  = coeff_q;
        x_d      = x_q;
        done_d   = 1'b0;
        shift    = 1'b0;
        shift_in = '0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = LOAD_COEFF;
                    cnt_d   = '0;
                end
                LOAD_COEFF: begin
                    if (coeffValid) begin
                        coeff_d[cnt_q] = coeffIn;
                        if (cnt_q == LAST_TAP) begin
                            state_d = MAIN_OP;
                            cnt_d   = '0;
                            x_d     = '{default: '0};
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                MAIN_OP: begin
                    if (dataInValid) begin
                        shift    = 1'b1;
                        shift_in = dataIn;
                    end
                    if (stopDataIn) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end
                end
                FLUSH: begin
                    shift = 1'b1;
                    if (cnt_q == LAST_FLUSH) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // x[0] is always the newest sample; flush cycles feed zeros.
        if (shift) begin
            for (int k = LENGTH - 1; k > 0; k--) begin
                x_d[k] = x_q[k-1];
            end
            x_d[0] = shift_in;
        end
    end

    // The output pair is computed from the register contents after this cycle's shift.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < LENGTH; k++) begin
            prod = PROD_W'(coeff_q[k]) * PROD_W'(x_d[k]);
            acc  = acc + ACC_W'(prod);
        end
    end

    always_comb begin
        valid_d = shift;
        re_d    = shift ? x_d[D] : '0;
        im_d    = shift ? shift_sat(acc) : '0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coeff_q <= '{default: '0};
            x_q     <= '{default: '0};
            re_q    <= '0;
            im_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coeff_q <= coeff_d;
            x_q     <= x_d;
            re_q    <= re_d;
            im_q    <= im_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign dataOutRe    = re_q;
    assign dataOutIm    = im_q;
    assign dataOutValid = valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_hilbert_transform_fir.sv
// Self-checking bench for hilbert_transform_fir against a sample-history reference model.
module tb_hilbert_transform_fir;

    localparam int LEN  = 27;
    localparam int D    = (LEN - 1) / 2;
    localparam int DW   = 18;
    localparam int CW   = 18;
    localparam int FRAC = 17;
    localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (DW - 1));

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] coeffIn = '0;
    logic          coeffValid = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          dataInValid = 1'b0;
    logic          stopDataIn = 1'b0;
    logic [DW-1:0] dataOutRe;
    logic [DW-1:0] dataOutIm;
    logic          dataOutValid;
    logic          done;

    int total = 0;
    int bad   = 0;

    int            mcoeff [LEN];
    int            hist [$];
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;

    hilbert_transform_fir #(
        .LENGTH(LEN), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRAC(FRAC)
    ) dut (
        .clock(clock), .resetN(resetN), .enable(enable),
        .coeffIn(coeffIn), .coeffValid(coeffValid),
        .dataIn(dataIn), .dataInValid(dataInValid), .stopDataIn(stopDataIn),
        .dataOutRe(dataOutRe), .dataOutIm(dataOutIm),
        .dataOutValid(dataOutValid), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic int rand_small();
        return int'($urandom_range(0, 16382)) - 8191;
    endfunction

    // Output pair the filter should produce from the current history: x[n-D] and
    // floor(sum h[k]*x[n-k] / 2^FRAC) clamped to the signed output range.
    task automatic model_eval();
        longint a = 0;
        for (int k = 0; k < LEN; k++) a += longint'(mcoeff[k]) * longint'(hist[k]);
        a = a >>> FRAC;
        if (a > SMAX) a = SMAX;
        else if (a < SMIN) a = SMIN;
        exp_im = DW'(a);
        exp_re = DW'(hist[D]);
    endtask

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < LEN; k++) hist.push_back(0);
    endtask

    task automatic model_push(input int v);
        hist.push_front(v);
        void'(hist.pop_back());
        model_eval();
    endtask

    task automatic start_run();
        enable = 1'b1; coeffValid = 1'b0; dataInValid = 1'b0; stopDataIn = 1'b0;
        tick();
        for (int k = 0; k < LEN; k++) begin
            coeffIn = CW'(mcoeff[k]); coeffValid = 1'b1;
            tick();
        end
        coeffValid = 1'b0;
        model_clear();
    endtask

    task automatic end_run();
        enable = 1'b0; coeffValid = 1'b0; dataInValid = 1'b0; stopDataIn = 1'b0;
        tick();
    endtask

    task automatic drive_sample(input int v, input logic stop);
        dataIn = DW'(v); dataInValid = 1'b1; stopDataIn = stop;
        tick();
        dataInValid = 1'b0; stopDataIn = 1'b0;
        model_push(v);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (dataOutValid !== 1'b0 || done !== 1'b0 || dataOutRe !== '0 || dataOutIm !== '0) begin
            bad++; $display("FAIL reset_async got v=%0b d=%0b re=%0d im=%0d want all 0",
                            dataOutValid, done, dataOutRe, dataOutIm);
        end
        enable = 1'b1; coeffValid = 1'b1; dataInValid = 1'b1; dataIn = DW'(777);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dataOutValid !== 1'b0 || done !== 1'b0 || dataOutRe !== '0 || dataOutIm !== '0) begin
                bad++; $display("FAIL reset_held[%0d] got v=%0b d=%0b re=%0d im=%0d want all 0",
                                i, dataOutValid, done, dataOutRe, dataOutIm);
            end
        end
        enable = 1'b0; resetN = 1'b1; stopDataIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dataOutValid !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL idle_ignore[%0d] got v=%0b d=%0b want 0 0", i, dataOutValid, done);
            end
        end
        end_run();
    endtask

    task automatic test_impulse();
        for (int k = 0; k < LEN; k++) mcoeff[k] = k * 4096;
        start_run();
        for (int i = 0; i < LEN; i++) begin
            drive_sample((i == 0) ? 32 : 0, 1'b0);
            total++;
            if (dataOutValid !== 1'b1 || $signed(dataOutIm) !== DW'(i) ||
                dataOutRe !== ((i == D) ? DW'(32) : DW'(0))) begin
                bad++; $display("FAIL impulse[%0d] got v=%0b re=%0d im=%0d want 1 %0d %0d", i,
                                dataOutValid, $signed(dataOutRe), $signed(dataOutIm),
                                (i == D) ? 32 : 0, i);
            end
        end
        end_run();
    endtask

    task automatic test_hilbert_dc();
        mcoeff[D] = 0;
        for (int k = 1; k <= D; k++) begin
            mcoeff[D-k] = int'($urandom_range(0, 60000)) - 30000;
            mcoeff[D+k] = -mcoeff[D-k];
        end
        start_run();
        for (int i = 0; i < 40; i++) begin
            drive_sample(1000, 1'b0);
            total++;
            if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL hilbert[%0d] got v=%0b re=%0d im=%0d want 1 %0d %0d", i,
                                dataOutValid, $signed(dataOutRe), $signed(dataOutIm),
                                $signed(exp_re), $signed(exp_im));
            end
            total++;
            if (dataOutRe !== ((i >= D) ? DW'(1000) : DW'(0)) ||
                (i >= LEN - 1 && dataOutIm !== DW'(0))) begin
                bad++; $display("FAIL hilbert_dc[%0d] got re=%0d im=%0d", i,
                                $signed(dataOutRe), $signed(dataOutIm));
            end
        end
        end_run();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < LEN; k++) mcoeff[k] = 131071;
        start_run();
        for (int i = 0; i < 60; i++) begin
            drive_sample((i < 30) ? 131071 : -131072, 1'b0);
            total++;
            if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL sat_model[%0d] got re=%0d im=%0d want %0d %0d", i,
                                $signed(dataOutRe), $signed(dataOutIm), $signed(exp_re), $signed(exp_im));
            end
            if ((i >= 1 && i < 30) || i >= 30 + LEN - 1) begin
                total++;
                if (dataOutIm !== ((i < 30) ? DW'(131071) : DW'(-131072))) begin
                    bad++; $display("FAIL sat_rail[%0d] got im=%0d want %0d", i, $signed(dataOutIm),
                                    (i < 30) ? 131071 : -131072);
                end
            end
        end
        end_run();
    endtask

    task automatic test_random_stream();
        int v;
        for (int k = 0; k < LEN; k++) mcoeff[k] = rand_small();
        start_run();
        for (int i = 0; i < 200; i++) begin
            coeffValid = 1'($urandom_range(0, 1));
            coeffIn = CW'(rand_sample());
            if ($urandom_range(0, 9) < 7) begin
                v = rand_sample();
                drive_sample(v, 1'b0);
                total++;
                if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                    bad++; $display("FAIL random[%0d] got v=%0b re=%0d im=%0d want 1 %0d %0d", i,
                                    dataOutValid, $signed(dataOutRe), $signed(dataOutIm),
                                    $signed(exp_re), $signed(exp_im));
                end
            end else begin
                tick();
                total++;
                if (dataOutValid !== 1'b0) begin
                    bad++; $display("FAIL random_gap[%0d] got v=%0b want 0", i, dataOutValid);
                end
            end
        end
        end_run();
        total++;
        if (dataOutValid !== 1'b0 || dataOutIm !== '0 || dataOutRe !== '0) begin
            bad++; $display("FAIL random_disable got v=%0b re=%0d im=%0d want 0", dataOutValid,
                            $signed(dataOutRe), $signed(dataOutIm));
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < LEN; k++) mcoeff[k] = rand_small();
        start_run();
        for (int i = 0; i < 5; i++) begin
            drive_sample(rand_sample(), i == 4);
            total++;
            if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL flush_in[%0d] got re=%0d im=%0d want %0d %0d", i,
                                $signed(dataOutRe), $signed(dataOutIm), $signed(exp_re), $signed(exp_im));
            end
        end
        for (int i = 0; i < LEN - 1; i++) begin
            dataInValid = 1'b1; dataIn = DW'(rand_sample());
            tick();
            model_push(0);
            total++;
            if (dataOutValid !== 1'b1 || done !== 1'b0 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL flush[%0d] got v=%0b d=%0b re=%0d im=%0d want 1 0 %0d %0d", i,
                                dataOutValid, done, $signed(dataOutRe), $signed(dataOutIm),
                                $signed(exp_re), $signed(exp_im));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (done !== 1'b1 || dataOutValid !== 1'b0 || dataOutRe !== '0 || dataOutIm !== '0) begin
                bad++; $display("FAIL stop[%0d] got d=%0b v=%0b re=%0d im=%0d want 1 0 0 0", i,
                                done, dataOutValid, $signed(dataOutRe), $signed(dataOutIm));
            end
        end
        end_run();
        total++;
        if (done !== 1'b0 || dataOutValid !== 1'b0) begin
            bad++; $display("FAIL stop_clear got d=%0b v=%0b want 0 0", done, dataOutValid);
        end
    endtask

    task automatic test_abort_load();
        enable = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            coeffIn = CW'(rand_sample()); coeffValid = 1'b1;
            tick();
        end
        coeffValid = 1'b0; enable = 1'b0;
        tick();
        total++;
        if (dataOutValid !== 1'b0 || done !== 1'b0 || dataOutRe !== '0 || dataOutIm !== '0) begin
            bad++; $display("FAIL abort_idle got v=%0b d=%0b re=%0d im=%0d want 0", dataOutValid, done,
                            $signed(dataOutRe), $signed(dataOutIm));
        end
        for (int k = 0; k < LEN; k++) mcoeff[k] = rand_small();
        enable = 1'b1;
        tick();
        for (int k = 0; k < LEN - 1; k++) begin
            coeffIn = CW'(mcoeff[k]); coeffValid = 1'b1;
            tick();
        end
        coeffValid = 1'b0; dataInValid = 1'b1; dataIn = DW'(5000);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (dataOutValid !== 1'b0) begin
                bad++; $display("FAIL reload_early[%0d] got v=%0b want 0", i, dataOutValid);
            end
        end
        dataInValid = 1'b0; coeffIn = CW'(mcoeff[LEN-1]); coeffValid = 1'b1;
        tick();
        coeffValid = 1'b0;
        model_clear();
        for (int i = 0; i < 30; i++) begin
            drive_sample(rand_sample(), 1'b0);
            total++;
            if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL reload[%0d] got v=%0b re=%0d im=%0d want 1 %0d %0d", i,
                                dataOutValid, $signed(dataOutRe), $signed(dataOutIm),
                                $signed(exp_re), $signed(exp_im));
            end
        end
        end_run();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < LEN; k++) mcoeff[k] = rand_small();
        start_run();
        for (int i = 0; i < 5; i++) drive_sample(rand_sample(), 1'b0);
        total++;
        if (dataOutValid !== 1'b1 || dataOutIm !== exp_im) begin
            bad++; $display("FAIL prereset got v=%0b im=%0d want 1 %0d", dataOutValid,
                            $signed(dataOutIm), $signed(exp_im));
        end
        #2 resetN = 1'b0;
        #1;
        total++;
        if (dataOutValid !== 1'b0 || done !== 1'b0 || dataOutRe !== '0 || dataOutIm !== '0) begin
            bad++; $display("FAIL async_reset got v=%0b d=%0b re=%0d im=%0d want 0", dataOutValid, done,
                            $signed(dataOutRe), $signed(dataOutIm));
        end
        tick();
        resetN = 1'b1; dataInValid = 1'b1; dataIn = DW'(1234);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (dataOutValid !== 1'b0) begin
                bad++; $display("FAIL postreset_ignore[%0d] got v=%0b want 0", i, dataOutValid);
            end
        end
        end_run();
        start_run();
        for (int i = 0; i < 10; i++) begin
            drive_sample(rand_sample(), 1'b0);
            total++;
            if (dataOutValid !== 1'b1 || dataOutIm !== exp_im || dataOutRe !== exp_re) begin
                bad++; $display("FAIL postreset_run[%0d] got re=%0d im=%0d want %0d %0d", i,
                                $signed(dataOutRe), $signed(dataOutIm), $signed(exp_re), $signed(exp_im));
            end
        end
        end_run();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_hilbert_dc();
        test_saturation();
        test_random_stream();
        test_flush();
        test_abort_load();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
